// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle MULTU/DIVU over the shared ALU; optional dz_err via DIV_BY_ZERO_FLAG_EN
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             alu_req,
  input  logic             alu_gnt,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_cout
`ifdef DIV_BY_ZERO_FLAG_EN
  ,
  output logic             dz_err
`endif
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, d_q, d_d;
  logic op_q, op_d;
  logic [WIDTH:0] r;
  logic ok;
`ifdef DIV_BY_ZERO_FLAG_EN
  logic dz_q, dz_d;
  assign dz_err = dz_q && state_q == DONE;
`endif
  assign busy    = state_q != IDLE;
  assign done    = state_q == DONE;
  assign alu_req = state_q == RUN;
  assign hi      = hi_q;
  assign lo      = lo_q;
  assign r       = {hi_q, lo_q[WIDTH-1]};
  assign ok      = r[WIDTH] | alu_cout;
  // next-state: operand setup on start, one shift-add / restoring-subtract step per grant
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    d_d     = d_q;
    op_d    = op_q;
`ifdef DIV_BY_ZERO_FLAG_EN
    dz_d    = dz_q;
`endif
    alu_a   = '0;
    alu_b   = '0;
    alu_op  = 3'b000;
    case (state_q)
      IDLE: if (start) begin
        op_d    = op;
        hi_d    = '0;
        lo_d    = op ? rs_val : rt_val;
        d_d     = op ? rt_val : rs_val;
        state_d = RUN;
`ifdef DIV_BY_ZERO_FLAG_EN
        dz_d    = op && rt_val == '0;
`endif
        if (op && rt_val == '0) begin
          hi_d    = rs_val;
          lo_d    = '1;
          state_d = DONE;
        end
      end
      RUN: begin
        alu_op = op_q ? 3'b110 : 3'b010;
        alu_a  = op_q ? r[WIDTH-1:0] : hi_q;
        alu_b  = (op_q || lo_q[0]) ? d_q : '0;
        if (alu_gnt) begin
          if (op_q) begin
            hi_d = ok ? alu_result : r[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], ok};
          end else
            {hi_d, lo_d} = {alu_cout, alu_result, lo_q[WIDTH-1:1]};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // state register with synchronous reset that abandons any operation in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      d_q     <= '0;
      op_q    <= 1'b0;
`ifdef DIV_BY_ZERO_FLAG_EN
      dz_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      d_q     <= d_d;
      op_q    <= op_d;
`ifdef DIV_BY_ZERO_FLAG_EN
      dz_q    <= dz_d;
`endif
    end
  end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed MULTU/DIVU vectors against a behavioural ALU
module tb_muldiv_sequencer;
  logic clk = 0, reset = 1, start = 0, op = 0, alu_gnt = 0, alu_cout;
  logic [31:0] rs_val = 0, rt_val = 0, hi, lo, alu_a, alu_b, alu_result;
  logic [2:0] alu_op;
  logic busy, done, alu_req;
  logic [32:0] sum;
  int n_chk = 0, n_pass = 0;
  int cyc, grants, viol;
  logic req_seen;
`ifdef DIV_BY_ZERO_FLAG_EN
  logic dz_err;
`endif
  always #5 clk = ~clk;
  muldiv_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .rs_val(rs_val), .rt_val(rt_val),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .alu_req(alu_req), .alu_gnt(alu_gnt),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result), .alu_cout(alu_cout)
`ifdef DIV_BY_ZERO_FLAG_EN
    , .dz_err(dz_err)
`endif
  );
  // ripple ALU stand-in: b optionally inverted with carry-in for subtract
  always_comb begin
    sum = {1'b0, alu_a} + {1'b0, alu_op[2] ? ~alu_b : alu_b} + {32'd0, alu_op[2]};
    alu_cout = sum[32];
    alu_result = alu_op[1:0] == 2'b00 ? (alu_a & alu_b) :
                 alu_op[1:0] == 2'b01 ? (alu_a | alu_b) :
                 alu_op[1:0] == 2'b10 ? sum[31:0] : {31'd0, sum[31]};
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic run(input logic o, input logic [31:0] a, input logic [31:0] b, input int toggle,
                     input int poke, output int c, output int g, output int v, output logic rs);
    logic held;
    logic [100:0] snap;
    logic gn;
    @(negedge clk);
    start = 1; op = o; rs_val = a; rt_val = b;
    @(negedge clk);
    start = 0;
    c = 1; g = 0; v = 0; rs = 0; held = 0; snap = '0;
    while (!done && c < 200) begin
      if (held && snap != {hi, lo, alu_a, alu_op, busy, alu_req}) v++;
      gn = toggle != 0 ? c % 2 == 1 : 1'b1;
      alu_gnt = gn;
      start = c == poke;
      if (c == poke) begin op = ~o; rs_val = 32'd99; rt_val = 32'd3; end
      rs |= alu_req;
      if (alu_req && gn) g++;
      held = alu_req && !gn;
      snap = {hi, lo, alu_a, alu_op, busy, alu_req};
      @(negedge clk);
      c++;
    end
    start = 0;
    rs |= alu_req;
  endtask
  initial begin
    repeat (2) @(negedge clk);
    reset = 0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_hilo", {hi, lo}, 0);
    check("rst_req", alu_req, 0);
    check("rst_alu", {alu_a, alu_b, alu_op}, 0);
    run(0, 7, 6, 0, 0, cyc, grants, viol, req_seen);
    check("mul7x6_lat", cyc, 33);
    check("mul7x6_busy", busy, 1);
    check("mul7x6_res", {hi, lo}, 64'd42);
    check("mul7x6_req_at_done", alu_req, 0);
    @(negedge clk);
    check("mul7x6_done_pulse", done, 0);
    check("mul7x6_idle", busy, 0);
    check("mul7x6_hold", {hi, lo}, 64'd42);
    run(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, cyc, grants, viol, req_seen);
    check("mulmax_res", {hi, lo}, 64'hFFFFFFFE_00000001);
    run(1, 100, 7, 1, 0, cyc, grants, viol, req_seen);
    check("div100_grants", grants, 32);
    check("div100_lat", cyc, 64);
    check("div100_hold", viol, 0);
    check("div100_res", {hi, lo}, {32'd2, 32'd14});
`ifdef DIV_BY_ZERO_FLAG_EN
    check("div100_dz", dz_err, 0);
`endif
    run(1, 32'hFFFFFFFF, 32'hFFFFFFFE, 0, 0, cyc, grants, viol, req_seen);
    check("divovf_res", {hi, lo}, {32'd1, 32'd1});
    run(1, 1234, 0, 0, 0, cyc, grants, viol, req_seen);
    check("div0_lat", cyc, 1);
    check("div0_res", {hi, lo}, {32'd1234, 32'hFFFFFFFF});
    check("div0_req", req_seen, 0);
`ifdef DIV_BY_ZERO_FLAG_EN
    check("div0_dz", dz_err, 1);
`endif
    @(negedge clk);
    check("div0_idle", busy, 0);
    run(0, 7, 6, 0, 5, cyc, grants, viol, req_seen);
    check("poke_lat", cyc, 33);
    check("poke_res", {hi, lo}, 64'd42);
    @(negedge clk);
    start = 1; op = 0; rs_val = 7; rt_val = 6;
    @(negedge clk);
    start = 0; alu_gnt = 1;
    repeat (10) @(negedge clk);
    check("mid_busy", busy, 1);
    reset = 1;
    @(negedge clk);
    reset = 0;
    check("midrst_busy", busy, 0);
    check("midrst_hilo", {hi, lo}, 0);
    check("midrst_req", alu_req, 0);
    repeat (3) @(negedge clk);
    check("midrst_stay_idle", {busy, done}, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
